// File: rtl/cache_fill_controller.sv
// Load/store sequencer in front of a direct-mapped, write-through data cache.
// Does the lookup, refills on load miss, writes stores through, counts misses.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_*               pipeline request; accepted on req_valid && req_ready
//   resp_valid/data     one-cycle completion pulse, load data (0 for stores)
//   cache_*             lookup address, write strobe/data/valid; hit/rdata back
//   mem_req_*           memory request held until mem_req_ready
//   mem_resp_*          memory read data or write acknowledge
//   miss_count          saturating load-miss counter
module cache_fill_controller #(
    parameter int INPUT_WIDTH = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [INPUT_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   req_ready,

    output logic                   resp_valid,
    output logic [DATA_WIDTH-1:0]  resp_data,

    output logic [INPUT_WIDTH-1:0] cache_addr,
    output logic                   cache_write,
    output logic [DATA_WIDTH-1:0]  cache_wdata,
    output logic                   cache_valid,
    input  logic                   cache_hit,
    input  logic [DATA_WIDTH-1:0]  cache_rdata,

    output logic                   mem_req_valid,
    output logic                   mem_req_write,
    output logic [INPUT_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0]  mem_req_wdata,
    input  logic                   mem_req_ready,
    input  logic                   mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]  mem_resp_data,

    output logic [CNT_WIDTH-1:0]   miss_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_FILL,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [INPUT_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  buf_q;
    logic                   write_q;
    logic                   hit_q;
    logic [CNT_WIDTH-1:0]   miss_q;

    logic                   accept;
    logic                   miss_inc;

    assign accept   = (state == S_IDLE) && req_valid;
    assign miss_inc = (state == S_LOOKUP) && !write_q && !cache_hit
                      && (miss_q != {CNT_WIDTH{1'b1}});

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Request registers, hit flag, data buffer and miss counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            hit_q   <= 1'b0;
            buf_q   <= '0;
            miss_q  <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                write_q <= req_write;
            end
            if (state == S_LOOKUP) begin
                hit_q <= cache_hit;
                buf_q <= cache_rdata;
            end
            // Write acknowledges carry no data; only loads refill the buffer.
            if ((state == S_MEM_WAIT) && mem_resp_valid && !write_q) begin
                buf_q <= mem_resp_data;
            end
            if (miss_inc) begin
                miss_q <= miss_q + CNT_WIDTH'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_nx = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!write_q && cache_hit) begin
                    state_nx = S_RESP;
                end else begin
                    state_nx = S_MEM_REQ;
                end
            end
            S_MEM_REQ: begin
                if (mem_req_ready) begin
                    state_nx = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                // A store only refreshes the line when it was already cached
                // (no write-allocate).
                if (mem_resp_valid) begin
                    if (!write_q || hit_q) begin
                        state_nx = S_FILL;
                    end else begin
                        state_nx = S_RESP;
                    end
                end
            end
            S_FILL: begin
                state_nx = S_RESP;
            end
            S_RESP: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Moore outputs: functions of state and latched request only
    always_comb begin
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_data     = '0;
        cache_addr    = '0;
        cache_write   = 1'b0;
        cache_wdata   = '0;
        cache_valid   = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;

        if (state != S_IDLE) begin
            cache_addr = addr_q;
        end

        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_LOOKUP: begin
            end
            S_MEM_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = write_q;
                mem_req_addr  = addr_q;
                mem_req_wdata = wdata_q;
            end
            S_MEM_WAIT: begin
            end
            S_FILL: begin
                cache_write = 1'b1;
                cache_valid = 1'b1;
                cache_wdata = write_q ? wdata_q : buf_q;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_data  = write_q ? '0 : buf_q;
            end
            default: begin
            end
        endcase
    end

    assign miss_count = miss_q;

endmodule
